// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM block.
package pwm_pkg;

    typedef enum logic {
        PWM_DIR_UP   = 1'b0,
        PWM_DIR_DOWN = 1'b1
    } pwm_dir_t;

    // Period reset value; the top level slices it down to its counter width.
    localparam logic [15:0] PWM_PER_RST_ALL1 = 16'hFFFF;

    function automatic int pwm_sel_w(input int ch);
        int w;
        w = $clog2(ch);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered compare value and registered compare output.
module pwm_channel #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic         wr,
    input  logic [W-1:0] data,
    input  logic [W-1:0] cnt,
    output logic         pwm
);

    logic [W-1:0] cmp_shadow_r;
    logic [W-1:0] cmp_act_r;
    logic         pwm_r;

    // Shadow compare register, written by the control interface.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_shadow_r <= {W{1'b0}};
        end else if (wr) begin
            cmp_shadow_r <= data;
        end
    end

    // Active compare register; a write in the load cycle bypasses the shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_act_r <= {W{1'b0}};
        end else if (load) begin
            cmp_act_r <= wr ? data : cmp_shadow_r;
        end
    end

    // Registered compare output, one cycle behind the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_r <= 1'b0;
        end else begin
            pwm_r <= en & (cnt < cmp_act_r);
        end
    end

    assign pwm = pwm_r;

endmodule

// File: rtl/pwm_multi_channel.sv
// CH-channel PWM with shared period counter and boundary-synchronous updates.
// Define PWM_CENTER_ALIGN_EN for a triangle (center-aligned) counter.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter  int CH = 4,
    parameter  int W  = 8,
    localparam int SW = pwm_sel_w(CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          per_we,
    input  logic [W-1:0]  per_data,
    input  logic          cmp_we,
    input  logic [SW-1:0] cmp_sel,
    input  logic [W-1:0]  cmp_data,
    output logic [CH-1:0] pwm,
    output logic [W-1:0]  cnt,
    output logic          pwm_start,
    output logic          upd_pend
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0]  cnt_r;
    logic [W-1:0]  cnt_nxt_s;
    logic [W-1:0]  per_shadow_r;
    logic [W-1:0]  per_act_r;
    logic          boundary_s;
    logic          load_s;
    logic          cmp_ok_s;
    logic          pwm_start_r;
    logic          upd_pend_r;
    logic          en_prev_r;
    logic [CH-1:0] pwm_s;

    // Load boundary detect; while disabled the active registers follow the shadows.
    always_comb begin
`ifdef PWM_CENTER_ALIGN_EN
        boundary_s = en & (cnt_r == CNT_ZERO);
`else
        boundary_s = en & (cnt_r == per_act_r);
`endif
        load_s   = boundary_s | ~en;
        cmp_ok_s = cmp_we & (int'(cmp_sel) < CH);
    end

`ifdef PWM_CENTER_ALIGN_EN
    pwm_dir_t dir_r;
    pwm_dir_t dir_nxt_s;

    // Triangle counter next state; PER=1 degenerates to 0,1,0,1 without turning down.
    always_comb begin
        cnt_nxt_s = cnt_r;
        dir_nxt_s = dir_r;
        if (!en || (per_act_r == CNT_ZERO)) begin
            cnt_nxt_s = CNT_ZERO;
            dir_nxt_s = PWM_DIR_UP;
        end else begin
            case (dir_r)
                PWM_DIR_UP: begin
                    if (cnt_r >= per_act_r) begin
                        cnt_nxt_s = per_act_r - CNT_ONE;
                        dir_nxt_s = (per_act_r == CNT_ONE) ? PWM_DIR_UP : PWM_DIR_DOWN;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                        dir_nxt_s = PWM_DIR_UP;
                    end
                end
                PWM_DIR_DOWN: begin
                    if (cnt_r <= CNT_ONE) begin
                        cnt_nxt_s = CNT_ZERO;
                        dir_nxt_s = PWM_DIR_UP;
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                        dir_nxt_s = PWM_DIR_DOWN;
                    end
                end
                default: begin
                    cnt_nxt_s = CNT_ZERO;
                    dir_nxt_s = PWM_DIR_UP;
                end
            endcase
        end
    end

    // Direction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_r <= PWM_DIR_UP;
        end else begin
            dir_r <= dir_nxt_s;
        end
    end
`else
    // Edge-aligned counter next state.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (!en || (cnt_r >= per_act_r)) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end
`endif

    // Counter, period start pulse and enable history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= CNT_ZERO;
            pwm_start_r <= 1'b0;
            en_prev_r   <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            pwm_start_r <= en & ((cnt_nxt_s == CNT_ZERO) | ~en_prev_r);
            en_prev_r   <= en;
        end
    end

    // Period shadow and active registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_shadow_r <= PWM_PER_RST_ALL1[W-1:0];
            per_act_r    <= PWM_PER_RST_ALL1[W-1:0];
        end else begin
            if (per_we) begin
                per_shadow_r <= per_data;
            end
            if (load_s) begin
                per_act_r <= per_we ? per_data : per_shadow_r;
            end
        end
    end

    // Pending flag: a boundary (or disable) always wins over a coincident write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_pend_r <= 1'b0;
        end else if (load_s) begin
            upd_pend_r <= 1'b0;
        end else if (per_we || cmp_ok_s) begin
            upd_pend_r <= 1'b1;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic wr_s;
        assign wr_s = cmp_we & (cmp_sel == SW'(i));

        pwm_channel #(
            .W(W)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .load (load_s),
            .wr   (wr_s),
            .data (cmp_data),
            .cnt  (cnt_r),
            .pwm  (pwm_s[i])
        );
    end

    assign pwm       = pwm_s;
    assign cnt       = cnt_r;
    assign pwm_start = pwm_start_r;
    assign upd_pend  = upd_pend_r;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed self-checking bench for pwm_multi_channel (CH=4,W=8 plus a CH=5 select-range instance).
module tb_pwm_multi_channel;

    localparam int CH = 4;
    localparam int W  = 8;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          en       = 1'b0;
    logic          per_we   = 1'b0;
    logic [W-1:0]  per_data = 8'h00;
    logic          cmp_we   = 1'b0;
    logic [1:0]    cmp_sel  = 2'd0;
    logic [W-1:0]  cmp_data = 8'h00;
    logic [CH-1:0] pwm;
    logic [W-1:0]  cnt;
    logic          pwm_start;
    logic          upd_pend;

    logic          en2       = 1'b0;
    logic          cmp_we2   = 1'b0;
    logic [2:0]    cmp_sel2  = 3'd0;
    logic [W-1:0]  cmp_data2 = 8'h00;
    logic          per_we2   = 1'b0;
    logic [W-1:0]  per_data2 = 8'h00;
    logic [4:0]    pwm_b;
    logic [W-1:0]  cnt_b;
    logic          start_b;
    logic          pend_b;

    int n_chk  = 0;
    int n_fail = 0;
    int hi[CH];
    int st;

    pwm_multi_channel #(.CH(CH), .W(W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .per_we(per_we), .per_data(per_data),
        .cmp_we(cmp_we), .cmp_sel(cmp_sel), .cmp_data(cmp_data),
        .pwm(pwm), .cnt(cnt), .pwm_start(pwm_start), .upd_pend(upd_pend)
    );

    pwm_multi_channel #(.CH(5), .W(W)) dut_b (
        .clk(clk), .rst(rst), .en(en2),
        .per_we(per_we2), .per_data(per_data2),
        .cmp_we(cmp_we2), .cmp_sel(cmp_sel2), .cmp_data(cmp_data2),
        .pwm(pwm_b), .cnt(cnt_b), .pwm_start(start_b), .upd_pend(pend_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++) begin
            if (pwm[i]) hi[i]++;
        end
        if (pwm_start) st++;
    endtask

    task automatic clr();
        for (int i = 0; i < CH; i++) hi[i] = 0;
        st = 0;
    endtask

    task automatic wr_cmp(input int sel, input int val);
        cmp_we   = 1'b1;
        cmp_sel  = 2'(sel);
        cmp_data = 8'(val);
        tick();
        cmp_we   = 1'b0;
    endtask

    task automatic wr_per(input int val);
        per_we   = 1'b1;
        per_data = 8'(val);
        tick();
        per_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
`ifdef PWM_CENTER_ALIGN_EN
        int exp_c[8];
`endif
        clr();
        #12;
        check_eq("rst_cnt", int'(cnt), 0);
        check_eq("rst_pwm", int'(pwm), 0);
        check_eq("rst_start", int'(pwm_start), 0);
        check_eq("rst_pend", int'(upd_pend), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Out-of-range channel selects on a CH=5 instance leave upd_pend alone.
        en2 = 1'b1; cmp_we2 = 1'b1; cmp_data2 = 8'd9;
        cmp_sel2 = 3'd5; tick();
        check_eq("sel5_ignored", int'(pend_b), 0);
        cmp_sel2 = 3'd7; tick();
        check_eq("sel7_ignored", int'(pend_b), 0);
        cmp_sel2 = 3'd4; tick();
        cmp_we2 = 1'b0;
        check_eq("sel4_pend", int'(pend_b), 1);
        en2 = 1'b0;

`ifdef PWM_CENTER_ALIGN_EN
        exp_c = '{1, 2, 3, 4, 3, 2, 1, 0};
        wr_per(4);
        wr_cmp(1, 2);
        en = 1'b1;
        clr();
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("ca_cnt", int'(cnt), exp_c[k]);
        end
        check_eq("ca_start_first", st, 2);
        clr();
        repeat (8) tick();
        check_eq("ca_hi1", hi[1], 3);
        check_eq("ca_start", st, 1);
`else
        // Test 1: PER=9, CMP={0,3,10,5}
        wr_per(9);
        wr_cmp(0, 0);
        wr_cmp(1, 3);
        wr_cmp(2, 10);
        wr_cmp(3, 5);
        check_eq("dis_pend", int'(upd_pend), 0);
        check_eq("dis_cnt", int'(cnt), 0);
        en = 1'b1;
        clr();
        tick();
        check_eq("e0_cnt", int'(cnt), 1);
        check_eq("e0_start", int'(pwm_start), 1);
        check_eq("e0_pwm", int'(pwm), 14);
        repeat (9) tick();
        check_eq("p1_hi0", hi[0], 0);
        check_eq("p1_hi1", hi[1], 3);
        check_eq("p1_hi2", hi[2], 10);
        check_eq("p1_hi3", hi[3], 5);
        check_eq("p1_start", st, 2);
        check_eq("p1_wrap", int'(cnt), 0);
        clr();
        repeat (10) tick();
        check_eq("p2_start", st, 1);
        check_eq("p2_cnt", int'(cnt), 0);
        check_eq("p2_hi3", hi[3], 5);

        // Test 2: mid-period compare write is deferred to the boundary
        clr();
        repeat (4) tick();
        check_eq("t2_cnt4", int'(cnt), 4);
        wr_cmp(1, 7);
        check_eq("t2_pend_set", int'(upd_pend), 1);
        repeat (4) tick();
        check_eq("t2_cnt9", int'(cnt), 9);
        check_eq("t2_pend_hold", int'(upd_pend), 1);
        tick();
        check_eq("t2_pend_clr", int'(upd_pend), 0);
        check_eq("t2_old_hi1", hi[1], 3);
        clr();
        repeat (9) tick();
        check_eq("t2_cnt9b", int'(cnt), 9);
        check_eq("t2_new_hi1", hi[1], 7);

        // Test 3: period write on the boundary cycle loads at once
        wr_per(4);
        check_eq("t3_pend", int'(upd_pend), 0);
        check_eq("t3_cnt", int'(cnt), 0);
        clr();
        repeat (5) tick();
        check_eq("t3_wrap5", int'(cnt), 0);
        check_eq("t3_start", st, 1);
        check_eq("t3_hi1_full", hi[1], 5);
        check_eq("t3_hi0", hi[0], 0);

        // Test 4: disable mid-period, write while disabled, re-enable
        repeat (3) tick();
        check_eq("t4_cnt3", int'(cnt), 3);
        en = 1'b0;
        tick();
        check_eq("t4_cnt_off", int'(cnt), 0);
        check_eq("t4_pwm_off", int'(pwm), 0);
        wr_cmp(3, 2);
        check_eq("t4_pend_off", int'(upd_pend), 0);
        tick();
        en = 1'b1;
        clr();
        tick();
        check_eq("t4_start_en", int'(pwm_start), 1);
        check_eq("t4_cnt1", int'(cnt), 1);
        repeat (4) tick();
        check_eq("t4_hi3", hi[3], 2);
        check_eq("t4_starts", st, 2);
        check_eq("t4_wrap", int'(cnt), 0);

        // Test 5: asynchronous reset mid-period
        wr_cmp(0, 1);
        check_eq("t5_pend", int'(upd_pend), 1);
        tick();
        check_eq("t5_cnt2", int'(cnt), 2);
        rst = 1'b1;
        #2;
        check_eq("t5_rst_cnt", int'(cnt), 0);
        check_eq("t5_rst_pwm", int'(pwm), 0);
        check_eq("t5_rst_start", int'(pwm_start), 0);
        check_eq("t5_rst_pend", int'(upd_pend), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr();
        repeat (20) tick();
        check_eq("t5_pwm_low", hi[0] + hi[1] + hi[2] + hi[3], 0);
        check_eq("t5_cnt20", int'(cnt), 20);
        check_eq("t5_start", st, 1);

        // PER=0: counter pinned at 0, every cycle a period start
        en = 1'b0;
        wr_per(0);
        wr_cmp(0, 1);
        tick();
        en = 1'b1;
        clr();
        repeat (5) tick();
        check_eq("p0_cnt", int'(cnt), 0);
        check_eq("p0_start", st, 5);
        check_eq("p0_hi0", hi[0], 5);
        check_eq("p0_hi1", hi[1], 0);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
